// File: rtl/fc1_in_deserializer.sv
// fc1_in_deserializer
//   Takes LII phy beats from the pool2 stage and feeds the fc1 HLS kernel input
//   stream. Beats whose dst is not NODE_ID are consumed and counted as drops.
//   Each accepted PW-bit word is held in a single register and sent out as
//   R = PW/OW slices, lowest slice first. The final slice of every
//   FRAME_WORDS-th word is marked with tlast.
//
// Ports
//   aclk, arst            clock; synchronous active-high reset
//   lii_in_p0_*           LII input beat (tdata/tvalid/tready, src/dst tags)
//   out_stream_*          OW-bit slice stream to the kernel (tdata/tvalid/tready/tlast)
//   ce                    kernel clock enable
//   frame_done            one-cycle pulse after the tlast slice handshake
//   last_src              src tag of the most recently accepted word
//   drop_cnt              saturating count of dropped (wrong-dst) beats
module fc1_in_deserializer #(
  parameter int       PW          = 1024,
  parameter int       OW          = 128,
  parameter logic [7:0] NODE_ID   = 8'd5,
  parameter int       FRAME_WORDS = 4
) (
  input  logic          aclk,
  input  logic          arst,
  input  logic [PW-1:0] lii_in_p0_tdata,
  input  logic          lii_in_p0_tvalid,
  output logic          lii_in_p0_tready,
  input  logic [7:0]    lii_in_p0_src,
  input  logic [7:0]    lii_in_p0_dst,
  output logic [OW-1:0] out_stream_tdata,
  output logic          out_stream_tvalid,
  input  logic          out_stream_tready,
  output logic          out_stream_tlast,
  output logic          ce,
  output logic          frame_done,
  output logic [7:0]    last_src,
  output logic [15:0]   drop_cnt
);

  localparam int R  = PW / OW;
  localparam int KW = (R > 1) ? $clog2(R) : 1;
  localparam int WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(R - 1);
  localparam logic [WW-1:0] W_LAST = WW'(FRAME_WORDS - 1);

  // Held word viewed as R slices so slice k is a plain index.
  logic [R-1:0][OW-1:0] word_q;
  logic                 full;
  logic [KW-1:0]        k;
  logic [WW-1:0]        w;

  logic k_last, in_hs, out_hs, match;

  assign k_last  = (k == K_LAST);
  assign match   = (lii_in_p0_dst == NODE_ID);
  // A new word may enter while the last slice of the current one leaves.
  assign lii_in_p0_tready = ~full | (k_last & out_stream_tready);
  assign in_hs   = lii_in_p0_tvalid & lii_in_p0_tready;
  assign out_hs  = full & out_stream_tready;

  assign out_stream_tvalid = full;
  assign out_stream_tdata  = word_q[k];
  assign out_stream_tlast  = full & k_last & (w == W_LAST);
  assign ce                = out_stream_tready | ~full;

  always_ff @(posedge aclk) begin
    if (arst) begin
      word_q     <= '0;
      full       <= 1'b0;
      k          <= '0;
      w          <= '0;
      frame_done <= 1'b0;
      last_src   <= 8'd0;
      drop_cnt   <= 16'd0;
    end else begin
      frame_done <= out_hs & out_stream_tlast;

      if (out_hs) begin
        if (k_last) begin
          k    <= '0;
          w    <= (w == W_LAST) ? '0 : w + 1'b1;
          full <= 1'b0;
        end else begin
          k <= k + 1'b1;
        end
      end

      // Placed after the slice update so a same-cycle load overrides the
      // EMPTY transition and restarts at slice 0.
      if (in_hs) begin
        if (match) begin
          word_q   <= lii_in_p0_tdata;
          k        <= '0;
          full     <= 1'b1;
          last_src <= lii_in_p0_src;
        end else if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fc1_in_deserializer.sv
module tb_fc1_in_deserializer;
  localparam int PW = 1024;
  localparam int OW = 128;
  localparam int R  = PW / OW;

  logic          aclk = 1'b0;
  logic          arst;
  logic [PW-1:0] in_tdata;
  logic          in_tvalid;
  logic          in_tready;
  logic [7:0]    in_src, in_dst;
  logic [OW-1:0] out_tdata;
  logic          out_tvalid, out_tready, out_tlast;
  logic          ce, frame_done;
  logic [7:0]    last_src;
  logic [15:0]   drop_cnt;

  fc1_in_deserializer #(.PW(PW), .OW(OW), .NODE_ID(8'd5), .FRAME_WORDS(4)) dut (
    .aclk(aclk), .arst(arst),
    .lii_in_p0_tdata(in_tdata), .lii_in_p0_tvalid(in_tvalid),
    .lii_in_p0_tready(in_tready), .lii_in_p0_src(in_src), .lii_in_p0_dst(in_dst),
    .out_stream_tdata(out_tdata), .out_stream_tvalid(out_tvalid),
    .out_stream_tready(out_tready), .out_stream_tlast(out_tlast),
    .ce(ce), .frame_done(frame_done), .last_src(last_src), .drop_cnt(drop_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [OW-1:0] d; logic l; int c; } ev_t;
  ev_t evq[$];
  ev_t eq[$];
  int  fdq[$];
  int  cyc = 0;
  int  n_cmp = 0, n_err = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  // Observed slice handshakes and frame_done pulses, sampled mid-cycle.
  always @(negedge aclk) begin
    if (!arst && out_tvalid && out_tready) evq.push_back('{out_tdata, out_tlast, cyc});
    if (frame_done) fdq.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mkw(input int base);
    logic [PW-1:0] v;
    v = '0;
    for (int i = 0; i < R; i++) v[i*OW +: OW] = OW'(base + i);
    return v;
  endfunction

  task automatic exp_word(input int base, input bit last_word);
    for (int i = 0; i < R; i++) eq.push_back('{OW'(base + i), last_word && (i == R-1), 0});
  endtask

  task automatic do_reset();
    arst = 1'b1;
    repeat (2) @(posedge aclk);
    #1 arst = 1'b0;
    evq.delete(); eq.delete(); fdq.delete();
  endtask

  // Presents one beat and returns 1 time unit after its accepting edge.
  task automatic send(input int base, input logic [7:0] dst, input logic [7:0] src, output int acc);
    in_tdata = mkw(base); in_dst = dst; in_src = src; in_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (in_tready) break;
    end
    chk("send_ready", OW'(in_tready), OW'(1));
    @(posedge aclk);
    #1 in_tvalid = 1'b0;
    acc = cyc;
  endtask

  task automatic cmp_stream(input string tag, input bit contig, input int first_c);
    chk({tag, "_count"}, OW'(evq.size()), OW'(eq.size()));
    for (int i = 0; i < eq.size() && i < evq.size(); i++) begin
      chk({tag, "_data"}, evq[i].d, eq[i].d);
      chk({tag, "_last"}, OW'(evq[i].l), OW'(eq[i].l));
      if (contig) chk({tag, "_cyc"}, OW'(evq[i].c), OW'(first_c + i));
    end
  endtask

  int a0, a1, a2, a3, sl;

  initial begin
    arst = 1'b1; in_tdata = '0; in_tvalid = 1'b0; in_src = 8'd0; in_dst = 8'd0;
    out_tready = 1'b1;

    // Reset state
    do_reset();
    @(negedge aclk);
    chk("rst_tvalid", OW'(out_tvalid), OW'(0));
    chk("rst_tlast",  OW'(out_tlast),  OW'(0));
    chk("rst_fdone",  OW'(frame_done), OW'(0));
    chk("rst_src",    OW'(last_src),   OW'(0));
    chk("rst_drops",  OW'(drop_cnt),   OW'(0));
    chk("rst_inrdy",  OW'(in_tready),  OW'(1));
    chk("rst_ce",     OW'(ce),         OW'(1));

    // Single word: slices 0..7 on consecutive cycles right after accept
    @(posedge aclk); #1;
    send(0, 8'd5, 8'h11, a0);
    repeat (12) @(posedge aclk); #1;
    exp_word(0, 1'b0);
    cmp_stream("single", 1'b1, a0);
    chk("single_fd", OW'(fdq.size()), OW'(0));

    // Four back-to-back words: 32 slices with no bubble, tlast on slice 31
    do_reset();
    send(100, 8'd5, 8'h01, a0);
    send(200, 8'd5, 8'h02, a1);
    send(300, 8'd5, 8'h03, a2);
    send(400, 8'd5, 8'h04, a3);
    repeat (12) @(posedge aclk); #1;
    exp_word(100, 0); exp_word(200, 0); exp_word(300, 0); exp_word(400, 1);
    cmp_stream("b2b", 1'b1, a0);
    chk("b2b_fd_n", OW'(fdq.size()), OW'(1));
    if (fdq.size() > 0 && evq.size() == 32) chk("b2b_fd_cyc", OW'(fdq[0]), OW'(evq[31].c + 1));

    // Kernel stall on slice 2 for three cycles
    do_reset();
    send(50, 8'd5, 8'h07, a0);
    repeat (2) @(posedge aclk);
    #1 out_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("stall_data",  out_tdata,          OW'(52));
      chk("stall_valid", OW'(out_tvalid),    OW'(1));
      chk("stall_inrdy", OW'(in_tready),     OW'(0));
      chk("stall_ce",    OW'(ce),            OW'(0));
    end
    @(posedge aclk);
    #1 out_tready = 1'b1;
    repeat (10) @(posedge aclk); #1;
    exp_word(50, 0);
    cmp_stream("stall", 1'b0, 0);

    // Interleaved foreign-dst beats: same output as without them
    do_reset();
    send(10, 8'd5, 8'h01, a0);
    send(999, 8'd3, 8'h33, a1);
    send(998, 8'd3, 8'h33, a1);
    send(20, 8'd5, 8'h02, a1);
    send(997, 8'd3, 8'h33, a2);
    send(30, 8'd5, 8'h03, a2);
    send(40, 8'd5, 8'h04, a3);
    repeat (12) @(posedge aclk); #1;
    exp_word(10, 0); exp_word(20, 0); exp_word(30, 0); exp_word(40, 1);
    cmp_stream("drop", 1'b0, 0);
    chk("drop_cnt3", OW'(drop_cnt), OW'(3));
    chk("drop_src",  OW'(last_src), OW'(8'h04));
    chk("drop_fd_n", OW'(fdq.size()), OW'(1));

    // src capture; an idle drop is consumed on its first cycle
    do_reset();
    send(0, 8'd5, 8'h11, a0);
    @(negedge aclk);
    chk("src_11", OW'(last_src), OW'(8'h11));
    repeat (10) @(posedge aclk); #1;
    send(0, 8'd5, 8'h22, a0);
    @(negedge aclk);
    chk("src_22", OW'(last_src), OW'(8'h22));
    repeat (10) @(posedge aclk); #1;
    sl = cyc;
    send(0, 8'd3, 8'h33, a0);
    chk("drop_1cyc", OW'(a0), OW'(sl + 1));
    @(negedge aclk);
    chk("src_keep", OW'(last_src), OW'(8'h22));
    chk("src_drops", OW'(drop_cnt), OW'(1));

    // Reset during slice 4 of word 2, then a clean frame
    do_reset();
    send(0, 8'd3, 8'h44, a0);
    send(100, 8'd5, 8'h01, a0);
    send(200, 8'd5, 8'h02, a1);
    repeat (4) @(posedge aclk);
    #1 chk("mid_slice4", out_tdata, OW'(204));
    arst = 1'b1;
    @(posedge aclk);
    #1 arst = 1'b0;
    @(negedge aclk);
    chk("mid_tvalid", OW'(out_tvalid), OW'(0));
    chk("mid_drops",  OW'(drop_cnt),   OW'(0));
    chk("mid_src",    OW'(last_src),   OW'(0));
    evq.delete(); eq.delete(); fdq.delete();
    @(posedge aclk); #1;
    send(500, 8'd5, 8'h05, a0);
    send(600, 8'd5, 8'h06, a1);
    send(700, 8'd5, 8'h07, a2);
    send(800, 8'd5, 8'h08, a3);
    repeat (12) @(posedge aclk); #1;
    exp_word(500, 0); exp_word(600, 0); exp_word(700, 0); exp_word(800, 1);
    cmp_stream("post", 1'b1, a0);
    chk("post_fd_n", OW'(fdq.size()), OW'(1));

    // drop_cnt saturation
    do_reset();
    in_dst = 8'd3; in_src = 8'h33; in_tvalid = 1'b1;
    repeat (1000) @(posedge aclk);
    @(negedge aclk);
    chk("sat_1000", OW'(drop_cnt), OW'(1000));
    repeat (65000) @(posedge aclk);
    @(negedge aclk);
    chk("sat_ffff", OW'(drop_cnt), OW'(16'hFFFF));
    chk("sat_tvalid", OW'(out_tvalid), OW'(0));
    in_tvalid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
